sobel_window_sequencer: RTL and testbench
=========================================

Name: sobel_window_sequencer

Overview:
- Sequences the 3x3 edge-detect window on the CCD write side: gates window/line-buffer shifts, tracks the window-centre coordinate, and flags border pixels.
- Aligns the CCD FIFO write enable with the convolution pipeline latency and flushes the line buffers at end of frame.
- Latches the edge/pass-through mode once per frame so a switch change never splits a frame.

Parameters:
WIDTH, 800, pixels per line
HEIGHT, 480, lines per frame
PIPE_LAT, 2, cycles from window shift to convolution result valid
CW, 10, column counter width (2^CW >= WIDTH)
RW, 9, row counter width (2^RW >= HEIGHT)

Ports:
CCD_FIFO_WRCLK  in  1  clock
RESET_N  in  1  reset, asynchronous, active-low
iFRAME_START  in  1  marks first pixel of frame; meaningful only with iPIX_VALID
iPIX_VALID  in  1  input pixel strobe
iMODE_REQ  in  1  requested mode (1 = edge detect), level
oSHIFT  out  1  advance window registers and line buffers this cycle
oFLUSH  out  1  current shift is a dummy; datapath injects zero pixel
oCTR_COL  out  CW  centre column, aligned to oOUT_WE
oCTR_ROW  out  RW  centre row, aligned to oOUT_WE
oBORDER  out  1  centre on frame border (datapath forces 0 in edge mode), aligned to oOUT_WE
oMODE_EDGE  out  1  mode latched for current frame
oOUT_WE  out  1  CCD FIFO write enable
oFRAME_DONE  out  1  one-cycle pulse after last output of frame
oERR  out  1  sticky protocol error

Behaviour:
- Reset: state IDLE; all counters, delay line and outputs 0. Asynchronous assert, synchronous release. Reset mid-frame drops everything in flight.
- Shift index s counts shifts within a frame from 0. Shift s >= WIDTH+1 is an output shift, placing pixel s-(WIDTH+1) at centre. Frame total: WIDTH*HEIGHT+WIDTH+1 shifts, WIDTH*HEIGHT output shifts.
- IDLE:
  - iPIX_VALID & iFRAME_START: oSHIFT=1 (s=0); latch oMODE_EDGE <= iMODE_REQ; input count=1; go PRIME.
  - iPIX_VALID alone: ignored, no shift.
- PRIME: each iPIX_VALID gives oSHIFT=1 and increments input count. The shift with s=WIDTH+1 is the first output shift: centre (0,0), go STREAM.
- STREAM:
  - Each iPIX_VALID gives an output shift; centre advances col+1, wrapping to 0 with row+1 at WIDTH-1.
  - When input count reaches WIDTH*HEIGHT, go FLUSH next cycle.
- FLUSH:
  - oSHIFT=oFLUSH=1 every cycle for WIDTH+1 cycles, each an output shift.
  - After the shift for centre (WIDTH-1,HEIGHT-1), go IDLE; oFRAME_DONE pulses when that output's oOUT_WE is emitted.
  - iPIX_VALID during FLUSH: pixel dropped, oERR<=1, flush unaffected.
- Frame-start errors: iFRAME_START&iPIX_VALID in PRIME or STREAM sets oERR<=1, abandons the frame and restarts as if from IDLE (s=0, mode relatched). Outputs already in the delay line still drain.
- Degenerate case: if WIDTH*HEIGHT < WIDTH+1, PRIME goes directly to FLUSH; not a supported configuration.
- Output alignment: delay line of PIPE_LAT stages carries {output-shift, col, row, border}. oOUT_WE = stage PIPE_LAT valid bit. oCTR_COL/ROW/oBORDER come from the same stage and are held at last value when oOUT_WE=0.
- Border: col==0 | col==WIDTH-1 | row==0 | row==HEIGHT-1.
- oMODE_EDGE changes only on an accepted frame start; mid-frame iMODE_REQ changes are ignored.
- Counters never exceed WIDTH-1/HEIGHT-1; no wrap beyond frame.

Test Plan:
Bench params: WIDTH=4, HEIGHT=3, PIPE_LAT=2.
- Contiguous frame: 12 back-to-back pixels, first with iFRAME_START -> first oOUT_WE 2 cycles after 6th pixel (s=5), centre (0,0); then 5 FLUSH cycles; exactly 12 oOUT_WE in raster order; oBORDER=0 only at (1,1),(2,1); one oFRAME_DONE with last oOUT_WE.
- Gapped input: same frame with iPIX_VALID every 3rd cycle -> identical centre sequence and 12 oOUT_WE; oSHIFT only on valid cycles until FLUSH, where 5 consecutive oSHIFT/oFLUSH.
- Mode: iMODE_REQ=1 at start, toggled to 0 at pixel 6 -> oMODE_EDGE=1 whole frame; next frame start with iMODE_REQ=0 -> oMODE_EDGE=0.
- Protocol errors: iPIX_VALID during FLUSH -> oERR=1, still 12 outputs and oFRAME_DONE. Separately, iFRAME_START at pixel 8 of STREAM -> oERR=1, new frame primes from s=0.
- Idle junk: 10 iPIX_VALID without iFRAME_START in IDLE -> oSHIFT=0, oOUT_WE=0 throughout.
- Reset mid-STREAM: RESET_N low at pixel 9 -> all outputs 0 immediately; after release, a full frame completes normally with oERR=0.

Source files
------------

// File: rtl/sobel_window_sequencer.sv
// Window sequencer for the 3x3 Sobel stage on the CCD write side: shift gating,
// centre tracking, border flags, write-enable alignment and end-of-frame flush.
module sobel_window_sequencer #(
  parameter int unsigned WIDTH    = 800,
  parameter int unsigned HEIGHT   = 480,
  parameter int unsigned PIPE_LAT = 2,
  parameter int unsigned CW       = 10,
  parameter int unsigned RW       = 9
) (
  input  logic          CCD_FIFO_WRCLK,
  input  logic          RESET_N,
  input  logic          iFRAME_START,
  input  logic          iPIX_VALID,
  input  logic          iMODE_REQ,
  output logic          oSHIFT,
  output logic          oFLUSH,
  output logic [CW-1:0] oCTR_COL,
  output logic [RW-1:0] oCTR_ROW,
  output logic          oBORDER,
  output logic          oMODE_EDGE,
  output logic          oOUT_WE,
  output logic          oFRAME_DONE,
  output logic          oERR
);

  localparam int unsigned NPIX = WIDTH * HEIGHT;
  localparam int unsigned NW   = $clog2(NPIX + 1);
  localparam int unsigned DW   = 1 + CW + RW;
  localparam int unsigned EW   = 2 + DW;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PRIME  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_FLUSH  = 2'd3;

  logic [1:0]    rst_sync_q;
  logic          rst_n;
  logic [1:0]    state_q, state_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          mode_q, mode_d;
  logic          err_q, err_d;
  logic          start_c, shift_c, flush_c, out_c, last_c, border_c;

  logic [EW-1:0]                  entry_c;
  logic [PIPE_LAT-1:0][EW-1:0]    dl_q;
  logic [PIPE_LAT:0][EW-1:0]      dl_next;

  // Asynchronous assert, synchronous release of the internal reset.
  always_ff @(posedge CCD_FIFO_WRCLK or negedge RESET_N) begin
    if (!RESET_N) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign start_c  = iPIX_VALID & iFRAME_START;
  assign border_c = (col_q == '0) || (col_q == CW'(WIDTH - 1)) ||
                    (row_q == '0) || (row_q == RW'(HEIGHT - 1));

  // Next state: a frame start restarts priming from any state except FLUSH.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    mode_d  = mode_q;
    err_d   = err_q;
    shift_c = 1'b0;
    flush_c = 1'b0;
    out_c   = 1'b0;
    last_c  = 1'b0;
    if (state_q == S_FLUSH) begin
      shift_c = 1'b1;
      flush_c = 1'b1;
      out_c   = 1'b1;
      if (iPIX_VALID) err_d = 1'b1;
      if (col_q == CW'(WIDTH - 1) && row_q == RW'(HEIGHT - 1)) begin
        last_c  = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    end else if (start_c) begin
      shift_c = 1'b1;
      mode_d  = iMODE_REQ;
      cnt_d   = NW'(1);
      col_d   = '0;
      row_d   = '0;
      state_d = S_PRIME;
      if (state_q != S_IDLE) err_d = 1'b1;
    end else if (iPIX_VALID && state_q != S_IDLE) begin
      shift_c = 1'b1;
      cnt_d   = cnt_q + NW'(1);
      out_c   = (state_q == S_STREAM) || (cnt_q == NW'(WIDTH + 1));
      if (cnt_d == NW'(NPIX)) state_d = S_FLUSH;
      else if (out_c)         state_d = S_STREAM;
    end
    if (out_c) begin
      if (col_q == CW'(WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CCD_FIFO_WRCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      dl_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      dl_q    <= dl_next[PIPE_LAT-1:0];
    end
  end

  // Idle entries copy the newest data so the oldest stage holds its last valid value.
  assign entry_c = {out_c, last_c, out_c ? {border_c, col_q, row_q} : dl_q[0][DW-1:0]};
  assign dl_next = {dl_q, entry_c};

  assign oSHIFT     = shift_c;
  assign oFLUSH     = flush_c;
  assign {oOUT_WE, oFRAME_DONE, oBORDER, oCTR_COL, oCTR_ROW} = dl_q[PIPE_LAT-1];
  assign oMODE_EDGE = mode_q;
  assign oERR       = err_q;

endmodule

// File: tb/tb_sobel_window_sequencer.sv
// Self-checking bench for sobel_window_sequencer: vector table, directed
// corner sequences and random stimulus against a shift-index reference model.
module tb_sobel_window_sequencer;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int PL   = 2;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fs = 1'b0, vld = 1'b0, mreq = 1'b0;
  logic       oSHIFT, oFLUSH, oBORDER, oMODE_EDGE, oOUT_WE, oFRAME_DONE, oERR;
  logic [2:0] oCTR_COL;
  logic [1:0] oCTR_ROW;

  always #5 clk = ~clk;

  sobel_window_sequencer #(.WIDTH(W), .HEIGHT(H), .PIPE_LAT(PL), .CW(3), .RW(2)) dut (
    .CCD_FIFO_WRCLK(clk), .RESET_N(rst_n), .iFRAME_START(fs), .iPIX_VALID(vld),
    .iMODE_REQ(mreq), .oSHIFT(oSHIFT), .oFLUSH(oFLUSH), .oCTR_COL(oCTR_COL),
    .oCTR_ROW(oCTR_ROW), .oBORDER(oBORDER), .oMODE_EDGE(oMODE_EDGE),
    .oOUT_WE(oOUT_WE), .oFRAME_DONE(oFRAME_DONE), .oERR(oERR));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: frame progress is just the shift index s.
  typedef struct { int due; int col; int row; bit last; } ev_t;
  ev_t q[$];
  int  t = 0, s = 0;
  bit  in_frame, m_err, m_mode, e_bord, e_done;
  int  e_col, e_row;
  int  cnt_we, cnt_done, cnt_flush, cnt_shift, cnt_b0;

  function automatic bit is_border(input int c, input int r);
    return (c == 0) || (c == W - 1) || (r == 0) || (r == H - 1);
  endfunction

  task automatic model_reset();
    q.delete();
    in_frame = 0; s = 0; m_err = 0; m_mode = 0;
    e_col = 0; e_row = 0; e_bord = 0; e_done = 0;
  endtask

  task automatic clr_counts();
    cnt_we = 0; cnt_done = 0; cnt_flush = 0; cnt_shift = 0; cnt_b0 = 0;
  endtask

  task automatic cycle(input bit v, input bit f, input bit m);
    ev_t ev;
    bit  e_we, e_sh, e_fl;
    int  sc, p;
    @(negedge clk);
    vld = v; fs = f; mreq = m;
    #1;
    e_we = 0; e_done = 0;
    if (q.size() > 0 && q[0].due == t) begin
      ev = q.pop_front();
      e_we = 1; e_col = ev.col; e_row = ev.row; e_done = ev.last;
      e_bord = is_border(ev.col, ev.row);
    end
    e_sh = 0; e_fl = 0; sc = 0;
    if (!in_frame) begin
      if (v && f) begin e_sh = 1; sc = 0; end
    end else if (s < NPIX) begin
      if (v && f)  begin e_sh = 1; sc = 0; end
      else if (v)  begin e_sh = 1; sc = s; end
    end else begin
      e_sh = 1; e_fl = 1; sc = s;
    end
    chk("shift", oSHIFT, e_sh);
    chk("flush", oFLUSH, e_fl);
    chk("out_we", oOUT_WE, e_we);
    chk("frame_done", oFRAME_DONE, e_done);
    chk("ctr_col", oCTR_COL, e_col);
    chk("ctr_row", oCTR_ROW, e_row);
    chk("border", oBORDER, e_bord);
    chk("mode_edge", oMODE_EDGE, m_mode);
    chk("err", oERR, m_err);
    cnt_we += oOUT_WE; cnt_done += oFRAME_DONE; cnt_flush += oFLUSH; cnt_shift += oSHIFT;
    if (oOUT_WE && !oBORDER) cnt_b0++;
    if (e_fl && v) m_err = 1;
    if (v && f && !e_fl) begin
      if (in_frame) m_err = 1;
      m_mode = m;
    end
    if (e_sh) begin
      if (sc >= W + 1) begin
        p = sc - (W + 1);
        q.push_back('{due: t + PL, col: p % W, row: p / W, last: (p == NPIX - 1)});
      end
      s = sc + 1;
      in_frame = (s != NPIX + W + 1);
    end
    t++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    vld = 0; fs = 0; mreq = 0; rst_n = 0;
    #1;
    chk("rst_shift", oSHIFT, 0);   chk("rst_flush", oFLUSH, 0);
    chk("rst_we", oOUT_WE, 0);     chk("rst_done", oFRAME_DONE, 0);
    chk("rst_col", oCTR_COL, 0);   chk("rst_row", oCTR_ROW, 0);
    chk("rst_border", oBORDER, 0); chk("rst_mode", oMODE_EDGE, 0);
    chk("rst_err", oERR, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (3) cycle(0, 0, 0);
  endtask

  task automatic frame(input int gap, input bit m);
    for (int i = 0; i < NPIX; i++) begin
      cycle(1, i == 0, m);
      repeat (gap) cycle(0, 0, m);
    end
    repeat (14) cycle(0, 0, m);
  endtask

  typedef struct { bit v; bit f; bit m; bit e_sh; bit e_we; int e_col; int e_row; } vec_t;
  vec_t tbl[12];

  initial begin
    // Junk, frame start, priming, first two outputs of a contiguous frame.
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 1, 1, 0, 0, 0};
    tbl[3]  = '{1, 0, 1, 1, 0, 0, 0};
    tbl[4]  = '{1, 0, 1, 1, 0, 0, 0};
    tbl[5]  = '{1, 0, 1, 1, 0, 0, 0};
    tbl[6]  = '{1, 0, 1, 1, 0, 0, 0};
    tbl[7]  = '{1, 0, 1, 1, 0, 0, 0};
    tbl[8]  = '{1, 0, 0, 1, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 1, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 1, 1, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 1, 0};

    model_reset();
    do_reset();

    clr_counts();
    repeat (10) cycle(1, 0, 1);
    chk("idle_junk_shift", cnt_shift, 0);
    chk("idle_junk_we", cnt_we, 0);

    clr_counts();
    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].f, tbl[i].m);
      chk("tbl_shift", oSHIFT, tbl[i].e_sh);
      chk("tbl_we", oOUT_WE, tbl[i].e_we);
      if (tbl[i].e_we) begin
        chk("tbl_col", oCTR_COL, tbl[i].e_col);
        chk("tbl_row", oCTR_ROW, tbl[i].e_row);
      end
    end
    repeat (5) cycle(1, 0, 0);
    repeat (14) cycle(0, 0, 0);
    chk("contig_we", cnt_we, 12);
    chk("contig_done", cnt_done, 1);
    chk("contig_nonborder", cnt_b0, 2);
    chk("contig_flush", cnt_flush, 5);
    chk("contig_mode", oMODE_EDGE, 1);

    clr_counts();
    frame(2, 0);
    chk("gap_we", cnt_we, 12);
    chk("gap_done", cnt_done, 1);
    chk("gap_flush", cnt_flush, 5);
    chk("gap_shift", cnt_shift, 17);
    chk("gap_mode", oMODE_EDGE, 0);

    clr_counts();
    for (int i = 0; i < NPIX; i++) cycle(1, i == 0, 1);
    cycle(0, 0, 1);
    cycle(1, 0, 1);
    repeat (12) cycle(0, 0, 1);
    chk("flusherr_err", oERR, 1);
    chk("flusherr_we", cnt_we, 12);
    chk("flusherr_done", cnt_done, 1);

    do_reset();
    clr_counts();
    for (int i = 0; i < 8; i++) cycle(1, i == 0, 0);
    for (int i = 0; i < NPIX; i++) cycle(1, i == 0, 1);
    repeat (14) cycle(0, 0, 0);
    chk("fserr_err", oERR, 1);
    chk("fserr_we", cnt_we, 3 + 12);
    chk("fserr_done", cnt_done, 1);
    chk("fserr_mode", oMODE_EDGE, 1);

    for (int i = 0; i < 400; i++) begin
      bit rv;
      rv = ($urandom_range(1) == 1);
      cycle(rv, rv && ($urandom_range(24) == 0), $urandom_range(1) == 1);
    end
    repeat (20) cycle(0, 0, 0);

    do_reset();
    for (int i = 0; i < 9; i++) cycle(1, i == 0, 1);
    do_reset();
    clr_counts();
    frame(0, 0);
    chk("postrst_err", oERR, 0);
    chk("postrst_we", cnt_we, 12);
    chk("postrst_done", cnt_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
